// File: rtl/mdu_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit: operation codes,
// FSM states and the fixed start-to-done latency.
package mdu_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10
  } mdu_state_e;

  localparam int MDU_DATA_WIDTH = 32;
  // Cycles busy is high for one operation: DATA_WIDTH steps plus the FIX cycle.
  localparam int MDU_LATENCY = MDU_DATA_WIDTH + 1;

endpackage

// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit: one shift-add or restoring
// subtract-shift step per cycle on magnitudes, with the sign fixed up at the end.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] rs_data,
  input  logic [DATA_WIDTH-1:0] rt_data,
  input  logic                  mthi,
  input  logic                  mtlo,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo,
  output logic [1:0]            state_dbg
);

  // Handshake: start is sampled only while busy=0 (IDLE, which includes the
  // cycle done is high); busy stays high until the result is written, and
  // done pulses for one cycle in the first IDLE cycle with hi/lo valid.
  localparam int CW = $clog2(DATA_WIDTH + 1);

  mdu_state_e            state;
  logic [CW-1:0]         cnt;
  logic                  is_div;
  logic                  neg_lo;
  logic                  neg_hi;
  logic                  div_zero;
  logic [DATA_WIDTH-1:0] acc_hi;
  logic [DATA_WIDTH-1:0] acc_lo;
  logic [DATA_WIDTH-1:0] opnd_b;
  logic [DATA_WIDTH-1:0] rs_raw;

  logic                  op_signed;
  logic                  a_neg;
  logic                  b_neg;
  logic [DATA_WIDTH-1:0] a_mag;
  logic [DATA_WIDTH-1:0] b_mag;

  assign op_signed = (mdu_op_e'(op) == OP_MULT) || (mdu_op_e'(op) == OP_DIV);
  assign a_neg     = op_signed && rs_data[DATA_WIDTH-1];
  assign b_neg     = op_signed && rt_data[DATA_WIDTH-1];
  assign a_mag     = a_neg ? ({DATA_WIDTH{1'b0}} - rs_data) : rs_data;
  assign b_mag     = b_neg ? ({DATA_WIDTH{1'b0}} - rt_data) : rt_data;

  // One iteration step. Multiply: acc_lo holds the multiplier and shifts the
  // product in from the top. Divide: acc_lo holds the dividend and collects
  // quotient bits, acc_hi is the partial remainder.
  logic [DATA_WIDTH:0]   mul_sum;
  logic [DATA_WIDTH:0]   div_shift;
  logic [DATA_WIDTH:0]   div_diff;
  logic                  div_ge;
  logic [DATA_WIDTH-1:0] step_hi;
  logic [DATA_WIDTH-1:0] step_lo;

  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd_b} : {(DATA_WIDTH+1){1'b0}});
    div_shift = {acc_hi, acc_lo[DATA_WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opnd_b});
    div_diff  = div_shift - {1'b0, opnd_b};
    step_hi   = '0;
    step_lo   = '0;
    if (is_div) begin
      step_hi = div_ge ? div_diff[DATA_WIDTH-1:0] : div_shift[DATA_WIDTH-1:0];
      step_lo = {acc_lo[DATA_WIDTH-2:0], div_ge};
    end else begin
      step_hi = mul_sum[DATA_WIDTH:1];
      step_lo = {mul_sum[0], acc_lo[DATA_WIDTH-1:1]};
    end
  end

  logic [2*DATA_WIDTH-1:0] prod;
  logic [2*DATA_WIDTH-1:0] prod_fix;
  logic [DATA_WIDTH-1:0]   fix_hi;
  logic [DATA_WIDTH-1:0]   fix_lo;

  always_comb begin
    prod     = {acc_hi, acc_lo};
    prod_fix = neg_lo ? ({(2*DATA_WIDTH){1'b0}} - prod) : prod;
    fix_hi   = prod_fix[2*DATA_WIDTH-1:DATA_WIDTH];
    fix_lo   = prod_fix[DATA_WIDTH-1:0];
    if (is_div) begin
      if (div_zero) begin
        fix_hi = rs_raw;
        fix_lo = '1;
      end else begin
        // Overflow 0x80.../-1 falls out naturally: negating 0x80... wraps to itself.
        fix_hi = neg_hi ? ({DATA_WIDTH{1'b0}} - acc_hi) : acc_hi;
        fix_lo = neg_lo ? ({DATA_WIDTH{1'b0}} - acc_lo) : acc_lo;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      is_div   <= 1'b0;
      neg_lo   <= 1'b0;
      neg_hi   <= 1'b0;
      div_zero <= 1'b0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      opnd_b   <= '0;
      rs_raw   <= '0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= CALC;
            cnt      <= '0;
            is_div   <= op[1];
            neg_lo   <= a_neg ^ b_neg;
            neg_hi   <= op[1] ? a_neg : (a_neg ^ b_neg);
            div_zero <= op[1] && (rt_data == '0);
            rs_raw   <= rs_data;
            acc_hi   <= '0;
            acc_lo   <= op[1] ? a_mag : b_mag;
            opnd_b   <= op[1] ? b_mag : a_mag;
          end else begin
            if (mthi) hi <= rs_data;
            if (mtlo) lo <= rs_data;
          end
        end
        CALC: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          cnt    <= cnt + 1'b1;
          if (cnt == CW'(DATA_WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          hi    <= fix_hi;
          lo    <= fix_lo;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign state_dbg = state;

endmodule
